// File: rtl/mid_pool_reader_pkg.sv
// ============================================================================
// mid_pool_reader_pkg : widths, default geometry and FSM encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package mid_pool_reader_pkg;

  localparam int DATA_W = 21;
  localparam int ADDR_W = 11;
  localparam logic [ADDR_W-1:0] IMAGE_WIDTH_DEF = 11'd28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mid_pool_reader_max3_s21.sv
// ============================================================================
// max3_s21 : combinational signed maximum of three samples
// Revision 1.0
// ============================================================================
`default_nettype none

module max3_s21
  import mid_pool_reader_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  logic [W-1:0] ab;

  assign ab = ($signed(a) > $signed(b)) ? a : b;
  assign y  = ($signed(ab) > $signed(c)) ? ab : c;

endmodule

`default_nettype wire

// File: rtl/mid_pool_reader.sv
// ============================================================================
// mid_pool_reader : reads a row pair from the row buffers, emits 2x2 max pool
// Revision 1.0
// ============================================================================
`default_nettype none

module mid_pool_reader
  import mid_pool_reader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] image_width = IMAGE_WIDTH_DEF,
  parameter int                data_width  = DATA_W
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  fin_rd,
  input  logic                  bram_toggle,
  input  logic [data_width-1:0] qa_0,
  input  logic [data_width-1:0] qa_1,
  input  logic [data_width-1:0] qa_2,
  input  logic [data_width-1:0] qa_3,
  input  logic [data_width-1:0] qb_0,
  input  logic [data_width-1:0] qb_1,
  input  logic [data_width-1:0] qb_2,
  input  logic [data_width-1:0] qb_3,
  input  logic [data_width-1:0] qc_0,
  input  logic [data_width-1:0] qc_1,
  input  logic [data_width-1:0] qc_2,
  input  logic [data_width-1:0] qc_3,
  output logic                  in0_rden,
  output logic                  in1_rden,
  output logic                  in2_rden,
  output logic                  in3_rden,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [data_width-1:0] out_a,
  output logic [data_width-1:0] out_b,
  output logic [data_width-1:0] out_c,
  output logic                  de_out,
  output logic                  busy,
  output logic                  overrun
);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   col;
  logic                sel;
  logic                drain_cnt;
  logic                rd_active;
  logic                last_col;
  logic                valid_d1;
  logic                par_d1;

  logic [data_width-1:0] hold_a, hold_b, hold_c;
  logic [data_width-1:0] up_a, up_b, up_c;
  logic [data_width-1:0] lo_a, lo_b, lo_c;
  logic [data_width-1:0] third_a, third_b, third_c;
  logic [data_width-1:0] max_a, max_b, max_c;

  assign last_col = (col == image_width - 1'b1);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_active  = 1'b0;
    case (state)
      ST_IDLE:  if (fin_rd) next_state = ST_READ;
      ST_READ: begin
        rd_active = 1'b1;
        if (last_col) next_state = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign in0_rden = rd_active & ~sel;
  assign in1_rden = rd_active & ~sel;
  assign in2_rden = rd_active &  sel;
  assign in3_rden = rd_active &  sel;
  assign rd_addr  = rd_active ? col : '0;

  // Bank data arrives one cycle after its address, so sel is still valid here.
  assign up_a = sel ? qa_2 : qa_0;
  assign lo_a = sel ? qa_3 : qa_1;
  assign up_b = sel ? qb_2 : qb_0;
  assign lo_b = sel ? qb_3 : qb_1;
  assign up_c = sel ? qc_2 : qc_0;
  assign lo_c = sel ? qc_3 : qc_1;

  // Even columns reuse the lower sample as the third operand (max of two).
  assign third_a = par_d1 ? hold_a : lo_a;
  assign third_b = par_d1 ? hold_b : lo_b;
  assign third_c = par_d1 ? hold_c : lo_c;

  max3_s21 #(.W(data_width)) u_max_a (.a(up_a), .b(lo_a), .c(third_a), .y(max_a));
  max3_s21 #(.W(data_width)) u_max_b (.a(up_b), .b(lo_b), .c(third_b), .y(max_b));
  max3_s21 #(.W(data_width)) u_max_c (.a(up_c), .b(lo_c), .c(third_c), .y(max_c));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      col       <= '0;
      sel       <= 1'b0;
      drain_cnt <= 1'b0;
      overrun   <= 1'b0;
      valid_d1  <= 1'b0;
      par_d1    <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
      hold_c    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      de_out    <= 1'b0;
    end else begin
      de_out   <= 1'b0;
      valid_d1 <= rd_active;
      par_d1   <= col[0];
      if (fin_rd && busy) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (fin_rd) begin
            sel <= bram_toggle;
            col <= '0;
          end
        end
        ST_READ:  col <= last_col ? '0 : col + 1'b1;
        ST_DRAIN: drain_cnt <= ~drain_cnt;
        default:  begin end
      endcase

      if (valid_d1) begin
        if (par_d1) begin
          out_a  <= max_a;
          out_b  <= max_b;
          out_c  <= max_c;
          de_out <= 1'b1;
        end else begin
          hold_a <= max_a;
          hold_b <= max_b;
          hold_c <= max_c;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mid_pool_reader.md
MID_POOL_READER -- requirements
Module: mid_pool_reader

Interface
REQ-001 Parameters: image_width, default 11'd28, pixels per row; data_width, default 21, sample width per channel.
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 fin_rd  input  1  one-cycle pulse from the row-buffer stage: a row pair is complete.
REQ-005 bram_toggle  input  1  row-buffer bank-pair indicator, sampled with fin_rd.
REQ-006 qa_0..qa_3, qb_0..qb_3, qc_0..qc_3  input  21 each  row-bank read data, channels a/b/c, banks 0-3.
REQ-007 in0_rden, in1_rden, in2_rden, in3_rden  output  1 each  bank read enables.
REQ-008 rd_addr  output  11  shared column read address.
REQ-009 out_a, out_b, out_c  output  21 each  2x2 max-pooled sample per channel.
REQ-010 de_out  output  1  out_* valid, one pooled pixel per asserted cycle.
REQ-011 busy  output  1  high while a row pair is being read and drained.
REQ-012 overrun  output  1  sticky: fin_rd arrived while busy.

Function
REQ-013 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-014 IDLE->READ on fin_rd=1; sel latched <= bram_toggle in that cycle; column counter col <= 0.
REQ-015 sel=0 selects banks 0 (upper row) and 1 (lower row); sel=1 selects banks 2 and 3.
REQ-016 In READ: rd_addr=col, the two selected rden=1, other two rden=0; col increments by 1 per cycle.
REQ-017 READ->DRAIN when col=image_width-1 is issued; DRAIN lasts 2 cycles, then IDLE; busy=1 in READ and DRAIN.
REQ-018 Bank read latency is 1 cycle: data for address issued in cycle k is on q* in cycle k+1.
REQ-019 For even column x: register per-channel max of upper/lower samples (hold_a/b/c).
REQ-020 For odd column x: out_* <= max(hold, upper, lower) per channel, de_out=1, in cycle k+2 where k is the cycle x was issued.
REQ-021 Comparisons are signed two's-complement over 21 bits; no widening, no saturation; equal values pass unchanged.
REQ-022 Pooled pixels per row pair = floor(image_width/2) (14 at default); odd image_width drops the last column.
REQ-023 de_out cycles are consecutive-odd-column spaced: one pulse every 2 cycles; out_* hold last value when de_out=0.
REQ-024 fin_rd while busy is ignored (no restart, sel unchanged), overrun <= 1 and stays 1 until RESET.
REQ-025 fin_rd in the same cycle as DRAIN->IDLE is treated as busy (ignored, overrun set).
REQ-026 rden outputs are 0 in IDLE and DRAIN; rd_addr is 0 in IDLE.

Reset
REQ-027 RESET asynchronously forces: state IDLE, col 0, sel 0, hold_* 0, out_* 0, de_out 0, all rden 0, rd_addr 0, busy 0, overrun 0.
REQ-028 RESET mid-READ abandons the row pair; no de_out pulse follows deassertion until the next fin_rd.

Structure
REQ-029 Shared package holds DATA_W=21, ADDR_W=11, default image_width 28, and the FSM state encoding.
REQ-030 One combinational sub-module max3_s21 (signed max of three 21-bit values), instantiated once per channel.
REQ-031 Row banks remain in the row-buffer stage; this block holds no memory beyond hold/out registers.

Verification
REQ-032 fin_rd with bram_toggle=0, bank0 col x = x, bank1 col x = 100+x (all channels) -> 14 de_out pulses, out_a = 101,103,...,127, in0/in1_rden high 28 cycles, in2/in3 low.
REQ-033 fin_rd with bram_toggle=1, bank2 = -5 constant, bank3 cols (0,1) = (-7,-3) -> first out = -3; only in2/in3_rden asserted.
REQ-034 Channel independence: qa=21'h0FFFFF, qb=21'h100000 (most negative), qc=0 -> out_a=21'h0FFFFF, out_b=21'h100000, out_c=0.
REQ-035 Second fin_rd 10 cycles after first -> ignored, overrun=1, exactly 14 pulses; overrun stays 1 after subsequent clean row pair.
REQ-036 RESET asserted at col=9 -> all outputs 0 immediately (asynchronously), no further de_out; next fin_rd yields a full 14-pulse row.
REQ-037 image_width=11'd7 -> 3 pulses, column 6 never pooled, READ lasts 7 cycles.
